// File: rtl/instruction_fetch_controller.sv
// Instruction fetch controller: owns the PC, reads the instruction ROM and
// buffers fetched words in an in-order queue presented to decode via valid/ready.
module instruction_fetch_controller #(
  parameter logic [31:0] RESET_PC    = 32'h0040_0000,
  parameter int unsigned TEXT_WORDS  = 18,
  parameter int unsigned QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_read_address,
  input  logic [31:0] imem_instruction,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        fault,
  output logic [31:0] fault_pc
);

  localparam int unsigned   CW         = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned   AW         = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam logic [31:0]   TEXT_END   = RESET_PC + 32'(4 * TEXT_WORDS);
  localparam logic [31:0]   IDLE_ADDR  = RESET_PC - 32'd4;
  localparam logic [CW-1:0] FULL_COUNT = CW'(QUEUE_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_STALL, S_FAULT} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  state_t        state;
  state_t        state_next;
  logic [31:0]   pc;
  logic [31:0]   pc_next;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [CW-1:0] wr_slot;
  entry_t        queue      [QUEUE_DEPTH];
  entry_t        queue_next [QUEUE_DEPTH];
  logic          push;
  logic          pop;
  logic          flush;
  logic          full;
  logic          room;
  logic          in_range;
  logic          misaligned;
  logic          fault_set;
  logic          fault_clr;
  logic [31:0]   fault_addr;

  assign full       = (count == FULL_COUNT);
  assign pop        = (count != '0) && inst_ready;
  assign room       = !full || pop;
  assign in_range   = (pc >= RESET_PC) && (pc < TEXT_END);
  assign misaligned = (redirect_pc[1:0] != 2'b00);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a redirect overrides enable and all normal sequencing
  always_comb begin
    state_next = state;
    if (redirect_valid) begin
      if (misaligned) begin
        state_next = S_FAULT;
      end else if (state != S_IDLE) begin
        state_next = S_FETCH;
      end
    end else if (enable) begin
      case (state)
        S_IDLE:  state_next = S_FETCH;
        S_FETCH: begin
          if (!in_range) begin
            state_next = S_FAULT;
          end else if (!room) begin
            state_next = S_STALL;
          end
        end
        S_STALL: begin
          if (!full) begin
            state_next = S_FETCH;
          end
        end
        default: state_next = state;
      endcase
    end
  end

  // Control outputs of the FSM: push, flush, PC update and fault capture
  always_comb begin
    push       = 1'b0;
    flush      = 1'b0;
    pc_next    = pc;
    fault_set  = 1'b0;
    fault_clr  = 1'b0;
    fault_addr = pc;
    if (redirect_valid) begin
      flush   = 1'b1;
      pc_next = redirect_pc;
      if (misaligned) begin
        fault_set  = 1'b1;
        fault_addr = redirect_pc;
      end else begin
        fault_clr = 1'b1;
      end
    end else if (enable && (state == S_FETCH)) begin
      if (!in_range) begin
        fault_set = 1'b1;
      end else if (room) begin
        push    = 1'b1;
        pc_next = pc + 32'd4;
      end
    end
  end

  // Queue occupancy; a flush wins over any same-cycle pop
  always_comb begin
    count_next = count;
    if (flush) begin
      count_next = '0;
    end else if (push && !pop) begin
      count_next = count + CW'(1);
    end else if (!push && pop) begin
      count_next = count - CW'(1);
    end
  end

  // Shift-down queue: entry 0 is always the head seen by decode
  always_comb begin
    wr_slot = pop ? (count - CW'(1)) : count;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      queue_next[i] = queue[i];
    end
    if (pop) begin
      for (int i = 0; i < QUEUE_DEPTH - 1; i++) begin
        queue_next[i] = queue[i + 1];
      end
    end
    if (push) begin
      queue_next[AW'(wr_slot)] = '{pc: pc, data: imem_instruction};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc                <= RESET_PC;
      count             <= '0;
      inst_valid        <= 1'b0;
      fault             <= 1'b0;
      fault_pc          <= '0;
      imem_read_address <= IDLE_ADDR;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        queue[i] <= '0;
      end
    end else begin
      pc                <= pc_next;
      count             <= count_next;
      inst_valid        <= (count_next != '0);
      imem_read_address <= (state_next == S_IDLE) ? IDLE_ADDR : pc_next;
      if (fault_set) begin
        fault    <= 1'b1;
        fault_pc <= fault_addr;
      end else if (fault_clr) begin
        fault <= 1'b0;
      end
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        queue[i] <= queue_next[i];
      end
    end
  end

  assign inst_data = queue[0].data;
  assign inst_pc   = queue[0].pc;

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Bench for instruction_fetch_controller: directed scenarios plus random traffic
// checked against a queue-based reference model of the fetch rules.
module tb_instruction_fetch_controller;

  localparam logic [31:0] RESET_PC   = 32'h0040_0000;
  localparam int unsigned TEXT_WORDS = 18;
  localparam int          DEPTH      = 2;
  localparam logic [31:0] TEXT_END   = RESET_PC + 32'(4 * TEXT_WORDS);
  localparam logic [31:0] IDLE_ADDR  = 32'h003F_FFFC;
  localparam int M_IDLE = 0, M_RUN = 1, M_STALL = 2, M_FAULT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_read_address;
  logic [31:0] imem_instruction;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        fault;
  logic [31:0] fault_pc;

  int total = 0;
  int bad   = 0;

  logic [31:0] rom [TEXT_WORDS];

  // Reference model state
  int          m_mode;
  logic [31:0] m_pc;
  logic [63:0] m_q [$];
  logic        m_fault;
  logic [31:0] m_fpc;

  instruction_fetch_controller dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .enable            (enable),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .imem_read_address (imem_read_address),
    .imem_instruction  (imem_instruction),
    .inst_valid        (inst_valid),
    .inst_ready        (inst_ready),
    .inst_data         (inst_data),
    .inst_pc           (inst_pc),
    .fault             (fault),
    .fault_pc          (fault_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    if (addr >= RESET_PC && addr < TEXT_END && addr[1:0] == 2'b00)
      return rom[int'((addr - RESET_PC) >> 2)];
    return 32'h0;
  endfunction

  assign imem_instruction = rom_word(imem_read_address);

  function automatic logic [31:0] exp_addr();
    return (m_mode == M_IDLE) ? IDLE_ADDR : m_pc;
  endfunction

  // One clock of the fetch rules, applied to the inputs seen at this edge
  task automatic model_step();
    bit pop;
    bit push;
    int sz;
    if (!rst_n) begin
      m_mode = M_IDLE; m_pc = RESET_PC; m_q.delete(); m_fault = 1'b0; m_fpc = 32'h0;
      return;
    end
    if (redirect_valid) begin
      m_q.delete();
      m_pc = redirect_pc;
      if (redirect_pc[1:0] != 2'b00) begin
        m_mode = M_FAULT; m_fault = 1'b1; m_fpc = redirect_pc;
      end else begin
        m_fault = 1'b0;
        if (m_mode != M_IDLE) m_mode = M_RUN;
      end
      return;
    end
    sz   = m_q.size();
    pop  = (sz > 0) && inst_ready;
    push = 1'b0;
    if (enable) begin
      case (m_mode)
        M_IDLE: m_mode = M_RUN;
        M_RUN: begin
          if (m_pc < RESET_PC || m_pc >= TEXT_END) begin
            m_mode = M_FAULT; m_fault = 1'b1; m_fpc = m_pc;
          end else if (sz < DEPTH || pop) begin
            push = 1'b1;
          end else begin
            m_mode = M_STALL;
          end
        end
        M_STALL: if (sz < DEPTH) m_mode = M_RUN;
        default: ;
      endcase
    end
    if (pop) void'(m_q.pop_front());
    if (push) begin
      m_q.push_back({m_pc, rom_word(m_pc)});
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset(input logic en, input logic rdy);
    rst_n = 1'b0; enable = en; inst_ready = rdy; redirect_valid = 1'b0; redirect_pc = 32'h0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(1'b0, 1'b0);
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", inst_valid); end
    total++; if (inst_data !== 32'h0) begin bad++; $display("FAIL reset_data: got %h want 0", inst_data); end
    total++; if (inst_pc !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h want 0", inst_pc); end
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL reset_fault: got %0b want 0", fault); end
    total++; if (fault_pc !== 32'h0) begin bad++; $display("FAIL reset_fault_pc: got %h want 0", fault_pc); end
    total++; if (imem_read_address !== IDLE_ADDR) begin bad++; $display("FAIL reset_addr: got %h want %h", imem_read_address, IDLE_ADDR); end
  endtask

  task automatic test_first_fetch();
    logic [31:0] exp_pc [3];
    logic [31:0] exp_d  [3];
    exp_pc[0] = 32'h0040_0000; exp_d[0] = 32'h012A_4020;
    exp_pc[1] = 32'h0040_0004; exp_d[1] = 32'h0232_8022;
    exp_pc[2] = 32'h0040_0008; exp_d[2] = 32'h8FB0_0010;
    do_reset(1'b1, 1'b1);
    tick();
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL first_latency: valid got %0b want 0 one cycle after reset", inst_valid); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (inst_valid !== 1'b1 || inst_pc !== exp_pc[i] || inst_data !== exp_d[i]) begin
        bad++;
        $display("FAIL first_word%0d: got v=%0b %h/%h want v=1 %h/%h", i, inst_valid, inst_pc, inst_data, exp_pc[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_stall();
    logic [63:0] got [$];
    int n;
    do_reset(1'b1, 1'b0);
    repeat (4) tick();
    total++; if (imem_read_address !== 32'h0040_0008) begin bad++; $display("FAIL stall_addr: got %h want 00400008", imem_read_address); end
    tick();
    total++; if (imem_read_address !== 32'h0040_0008 || inst_pc !== RESET_PC) begin bad++; $display("FAIL stall_hold: got addr %h head %h want 00400008 00400000", imem_read_address, inst_pc); end
    inst_ready = 1'b1;
    n = 0;
    while (got.size() < 4 && n < 20) begin
      if (inst_valid) got.push_back({inst_pc, inst_data});
      tick(); n++;
    end
    total++;
    if (got.size() < 4) begin bad++; $display("FAIL stall_drain: got %0d words want 4 within 20 cycles", got.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        logic [31:0] a;
        a = RESET_PC + 32'(4 * i);
        total++;
        if (got[i] !== {a, rom_word(a)}) begin bad++; $display("FAIL stall_order%0d: got %h want %h", i, got[i], {a, rom_word(a)}); end
      end
    end
  endtask

  task automatic test_redirect_flush();
    do_reset(1'b1, 1'b0);
    repeat (4) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0040_0004;
    tick();
    redirect_valid = 1'b0;
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL flush_valid: got %0b want 0", inst_valid); end
    tick();
    total++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h0040_0004 || inst_data !== 32'h0232_8022) begin
      bad++; $display("FAIL flush_refetch: got v=%0b %h/%h want v=1 00400004/02328022", inst_valid, inst_pc, inst_data);
    end
  endtask

  task automatic test_enable_low();
    do_reset(1'b1, 1'b0);
    repeat (4) tick();
    enable = 1'b0; inst_ready = 1'b1;
    repeat (3) tick();
    total++; if (inst_valid !== 1'b0 || imem_read_address !== 32'h0040_0008) begin bad++; $display("FAIL enable_low: got v=%0b addr %h want v=0 addr 00400008", inst_valid, imem_read_address); end
    enable = 1'b1;
    tick();
    tick();
    total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0040_0008) begin bad++; $display("FAIL enable_resume: got v=%0b pc %h want v=1 00400008", inst_valid, inst_pc); end
  endtask

  task automatic test_end_of_text();
    logic [63:0] got [$];
    int n;
    do_reset(1'b1, 1'b1);
    n = 0;
    while (fault !== 1'b1 && n < 60) begin
      if (inst_valid) got.push_back({inst_pc, inst_data});
      tick(); n++;
    end
    total++; if (fault !== 1'b1) begin bad++; $display("FAIL eot_fault: fault got %0b want 1 within 60 cycles", fault); end
    total++; if (fault_pc !== 32'h0040_0048) begin bad++; $display("FAIL eot_fault_pc: got %h want 00400048", fault_pc); end
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL eot_drained: valid got %0b want 0", inst_valid); end
    total++;
    if (got.size() != int'(TEXT_WORDS)) begin bad++; $display("FAIL eot_count: got %0d words want %0d", got.size(), TEXT_WORDS); end
    else if (got[TEXT_WORDS-1] !== {32'h0040_0044, rom[TEXT_WORDS-1]}) begin bad++; $display("FAIL eot_last: got %h want 00400044 %h", got[TEXT_WORDS-1], rom[TEXT_WORDS-1]); end
    redirect_valid = 1'b1; redirect_pc = RESET_PC;
    tick();
    redirect_valid = 1'b0;
    total++; if (fault !== 1'b0 || fault_pc !== 32'h0040_0048) begin bad++; $display("FAIL eot_clear: got fault %0b pc %h want 0 00400048", fault, fault_pc); end
    tick();
    total++; if (inst_valid !== 1'b1 || inst_pc !== RESET_PC || inst_data !== 32'h012A_4020) begin bad++; $display("FAIL eot_restart: got v=%0b %h/%h want v=1 00400000/012A4020", inst_valid, inst_pc, inst_data); end
  endtask

  task automatic test_misaligned();
    redirect_valid = 1'b1; redirect_pc = 32'h0040_0002;
    tick();
    redirect_valid = 1'b0;
    total++; if (fault !== 1'b1 || fault_pc !== 32'h0040_0002) begin bad++; $display("FAIL misalign_fault: got %0b %h want 1 00400002", fault, fault_pc); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (inst_valid !== 1'b0 || imem_read_address !== 32'h0040_0002) begin bad++; $display("FAIL misalign_nopush%0d: got v=%0b addr %h want v=0 00400002", i, inst_valid, imem_read_address); end
      tick();
    end
  endtask

  task automatic test_reset_in_stall();
    do_reset(1'b1, 1'b0);
    repeat (4) tick();
    rst_n = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0040_0010; inst_ready = 1'b1;
    tick();
    total++;
    if (inst_valid !== 1'b0 || inst_data !== 32'h0 || inst_pc !== 32'h0 || fault !== 1'b0 || fault_pc !== 32'h0 || imem_read_address !== IDLE_ADDR) begin
      bad++; $display("FAIL reset_stall: got v=%0b d=%h p=%h f=%0b fp=%h a=%h want all zero a=003ffffc",
                      inst_valid, inst_data, inst_pc, fault, fault_pc, imem_read_address);
    end
    rst_n = 1'b1; redirect_valid = 1'b0;
  endtask

  task automatic test_random();
    do_reset(1'b1, 1'b1);
    for (int c = 0; c < 600; c++) begin
      rst_n          = ($urandom_range(0, 99) != 0);
      enable         = ($urandom_range(0, 9) != 0);
      inst_ready     = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 14) == 0);
      redirect_pc    = RESET_PC - 32'd8 + 32'(4 * $urandom_range(0, 23));
      if ($urandom_range(0, 7) == 0) redirect_pc[1:0] = 2'($urandom_range(1, 3));
      tick();
      total++; if (inst_valid !== (m_q.size() != 0)) begin bad++; $display("FAIL rnd_valid c%0d: got %0b want %0b", c, inst_valid, m_q.size() != 0); end
      if (m_q.size() != 0) begin
        total++; if ({inst_pc, inst_data} !== m_q[0]) begin bad++; $display("FAIL rnd_head c%0d: got %h/%h want %h", c, inst_pc, inst_data, m_q[0]); end
      end
      total++; if (fault !== m_fault || fault_pc !== m_fpc) begin bad++; $display("FAIL rnd_fault c%0d: got %0b %h want %0b %h", c, fault, fault_pc, m_fault, m_fpc); end
      total++; if (imem_read_address !== exp_addr()) begin bad++; $display("FAIL rnd_addr c%0d: got %h want %h", c, imem_read_address, exp_addr()); end
    end
  endtask

  initial begin
    rom[0] = 32'h012A_4020;
    rom[1] = 32'h0232_8022;
    rom[2] = 32'h8FB0_0010;
    for (int i = 3; i < int'(TEXT_WORDS); i++) rom[i] = $urandom;
    rst_n = 1'b0; enable = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b0;
    test_reset();
    test_first_fetch();
    test_stall();
    test_redirect_flush();
    test_enable_low();
    test_end_of_text();
    test_misaligned();
    test_reset_in_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
